// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Sizing functions take WIDTH/DIGIT so each instance computes its own.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsa_state_t;

  localparam int DSA_WIDTH_DFLT = 16;
  localparam int DSA_DIGIT_DFLT = 4;

  function automatic int dsa_ndig(int w, int d);
    return w / d;
  endfunction

  function automatic int dsa_cnt_w(int w, int d);
    return (w / d > 1) ? $clog2(w / d) : 1;
  endfunction

  // Nonzero means WIDTH is not a whole number of digits.
  function automatic int dsa_width_rem(int w, int d);
    return w % d;
  endfunction

endpackage

// File: rtl/digit_adder_slice.sv
// DIGIT-wide ripple chain of full-adder cells.
// The carry-into-MSB tap exists only when DSA_OVF_EN is defined.
module digit_adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
`ifdef DSA_OVF_EN
  , output logic           c_msb_in
`endif
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DIGIT];

`ifdef DSA_OVF_EN
  assign c_msb_in = c[DIGIT-1];
`endif

endmodule

// File: rtl/digit_serial_adder.sv
// WIDTH-bit adder computing DIGIT bits per clock over valid/ready.
// Define DSA_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DSA_WIDTH_DFLT,
  parameter int DIGIT = DSA_DIGIT_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef DSA_OVF_EN
  , output logic           ovf
`endif
);

  localparam int NDIG = dsa_ndig(WIDTH, DIGIT);
  localparam int CW   = dsa_cnt_w(WIDTH, DIGIT);
  localparam int WREM = dsa_width_rem(WIDTH, DIGIT);

  if (WIDTH < 1 || WREM != 0) begin : g_bad_cfg
    $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  dsa_state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, sum_nx;
  logic [DIGIT-1:0] d_sum;
  logic [CW-1:0]    cnt;
  logic             carry, d_cout;
  logic             accept, step, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_ready & in_valid;
  assign step   = (state == RUN);
  assign last   = step && (cnt == CW'(NDIG - 1));

  // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB.
  assign sum_nx = (sum >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

`ifdef DSA_OVF_EN
  logic c_msb;

  digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_sr[DIGIT-1:0]),
    .b        (b_sr[DIGIT-1:0]),
    .cin      (carry),
    .s        (d_sum),
    .cout     (d_cout),
    .c_msb_in (c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= c_msb ^ d_cout;
  end
`else
  digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (carry),
    .s    (d_sum),
    .cout (d_cout)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      carry <= d_cout;
      sum   <= sum_nx;
      if (last) cout <= d_cout;
      else      cnt  <= cnt + CW'(1);
    end
  end

endmodule
